// File: rtl/rca_config.sv
// Shared definitions for the RCA writeback arbiter: default sizes,
// the FSM state type and per-unit array typedefs.
package rca_config;

  localparam int WB_NUM_UNITS = 4;
  localparam int WB_XLEN      = 32;
  localparam int WB_COUNT_W   = 16;
  localparam int WB_RD_W      = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wb_state_t;

  typedef logic [WB_NUM_UNITS-1:0][WB_RD_W-1:0]    wb_rd_array_t;
  typedef logic [WB_NUM_UNITS-1:0][WB_COUNT_W-1:0] wb_count_array_t;

endpackage

// File: rtl/rca_rr_picker.sv
// Combinational round-robin picker: grants the first requester found
// searching upward from the pointer, wrapping past the top index.
module rca_rr_picker #(
  parameter int N = 4,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [PTR_W-1:0] o_grant_idx,
  output logic             o_any_grant
);

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_cand;

  // Rotating-priority search; the first hit wins and later hits are ignored.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any_grant = 1'b0;
    w_sum       = '0;
    w_cand      = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = {1'b0, i_ptr} + (PTR_W+1)'(i);
      if (w_sum >= (PTR_W+1)'(N)) begin
        w_sum = w_sum - (PTR_W+1)'(N);
      end
      w_cand = w_sum[PTR_W-1:0];
      if (!o_any_grant && i_req[w_cand]) begin
        o_any_grant     = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_grant_idx     = w_cand;
      end
    end
  end

endmodule

// File: rtl/rca_writeback_arbiter.sv
// Drains IO-unit output FIFOs under round-robin arbitration into a
// registered valid/ack writeback stage and signals run completion.
// Optional stall counter enabled by defining RCA_WB_PERF_EN.
module rca_writeback_arbiter
  import rca_config::*;
#(
  parameter int NUM_IO_UNITS = WB_NUM_UNITS,
  parameter int XLEN         = WB_XLEN,
  parameter int COUNT_W      = WB_COUNT_W,
  parameter int RD_W         = WB_RD_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  input  logic [NUM_IO_UNITS-1:0]         out_mask,
  input  logic [NUM_IO_UNITS*RD_W-1:0]    rd_addrs,
  input  logic [NUM_IO_UNITS*COUNT_W-1:0] expected_count,
  input  logic [NUM_IO_UNITS*XLEN-1:0]    io_unit_data_out,
  input  logic [NUM_IO_UNITS-1:0]         io_unit_data_valid_out,
  output logic [NUM_IO_UNITS-1:0]         io_fifo_pop,
  output logic                            wb_valid,
  output logic [RD_W-1:0]                 wb_rd,
  output logic [XLEN-1:0]                 wb_data,
  input  logic                            wb_ack,
  output logic                            busy,
  output logic                            done,
  output logic [31:0]                     perf_stall_cycles
);

  localparam int PTR_W = (NUM_IO_UNITS > 1) ? $clog2(NUM_IO_UNITS) : 1;

  wb_state_t                    r_state;
  logic [NUM_IO_UNITS-1:0]      r_mask;
  logic [NUM_IO_UNITS*RD_W-1:0] r_rd_flat;
  logic [PTR_W-1:0]             r_ptr;
  logic                         r_wb_valid;
  logic [RD_W-1:0]              r_wb_rd;
  logic [XLEN-1:0]              r_wb_data;

  logic [NUM_IO_UNITS-1:0]      w_cnt_nz;
  logic [NUM_IO_UNITS-1:0]      w_eligible;
  logic [NUM_IO_UNITS-1:0]      w_grant;
  logic [PTR_W-1:0]             w_grant_idx;
  logic                         w_any_grant;
  logic                         w_capture;
  logic                         w_all_zero;
  logic [XLEN-1:0]              w_data_arr [NUM_IO_UNITS];
  logic [RD_W-1:0]              w_rd_arr   [NUM_IO_UNITS];

  // Per-unit remaining counters, eligibility and unpacked data/rd views.
  for (genvar gi = 0; gi < NUM_IO_UNITS; gi++) begin : g_unit
    logic [COUNT_W-1:0] r_remaining;

    // Load on start (masked units get 0), clear on abort, decrement on pop.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_remaining <= '0;
      end else if (r_state == IDLE && start) begin
        r_remaining <= out_mask[gi] ? expected_count[gi*COUNT_W +: COUNT_W] : '0;
      end else if (r_state == RUN && abort) begin
        r_remaining <= '0;
      end else if (io_fifo_pop[gi]) begin
        r_remaining <= r_remaining - COUNT_W'(1);
      end
    end

    assign w_cnt_nz[gi]   = |r_remaining;
    assign w_eligible[gi] = r_mask[gi] & io_unit_data_valid_out[gi] & w_cnt_nz[gi];
    assign w_data_arr[gi] = io_unit_data_out[gi*XLEN +: XLEN];
    assign w_rd_arr[gi]   = r_rd_flat[gi*RD_W +: RD_W];
  end

  rca_rr_picker #(
    .N (NUM_IO_UNITS)
  ) u_picker (
    .i_req       (w_eligible),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any_grant (w_any_grant)
  );

  // Abort outranks capture; a capture needs an empty or draining output slot.
  assign w_capture   = (r_state == RUN) && !abort && (!r_wb_valid || wb_ack) && w_any_grant;
  assign w_all_zero  = ~|w_cnt_nz;
  assign io_fifo_pop = w_capture ? w_grant : '0;

  // Control FSM with the writeback output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_mask     <= '0;
      r_rd_flat  <= '0;
      r_ptr      <= '0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state   <= RUN;
            r_mask    <= out_mask;
            r_rd_flat <= rd_addrs;
            r_ptr     <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            r_state    <= IDLE;
            r_wb_valid <= 1'b0;
          end else begin
            if (w_capture) begin
              r_wb_valid <= 1'b1;
              r_wb_data  <= w_data_arr[w_grant_idx];
              r_wb_rd    <= w_rd_arr[w_grant_idx];
              r_ptr      <= (w_grant_idx == PTR_W'(NUM_IO_UNITS-1)) ? '0
                                                                    : w_grant_idx + PTR_W'(1);
            end else if (wb_ack) begin
              r_wb_valid <= 1'b0;
            end
            // No capture is possible once every count is zero.
            if (w_all_zero && (!r_wb_valid || wb_ack)) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign wb_valid = r_wb_valid;
  assign wb_rd    = r_wb_rd;
  assign wb_data  = r_wb_data;
  assign busy     = (r_state == RUN);
  assign done     = (r_state == DONE);

`ifdef RCA_WB_PERF_EN
  logic [31:0] r_perf_stall;

  // Saturating count of cycles the writeback port refused a pending result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_stall <= '0;
    end else if (r_state == IDLE && start) begin
      r_perf_stall <= '0;
    end else if (r_state == RUN && r_wb_valid && !wb_ack && r_perf_stall != 32'hFFFF_FFFF) begin
      r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_stall_cycles = r_perf_stall;
`else
  assign perf_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_rca_writeback_arbiter.sv
// Directed self-checking bench for rca_writeback_arbiter with a simple
// per-unit FIFO model feeding the IO-unit inputs.
module tb_rca_writeback_arbiter;

  logic         clk;
  logic         rst;
  logic         start;
  logic         abort;
  logic [3:0]   out_mask;
  logic [19:0]  rd_addrs;
  logic [63:0]  exp_cnt;
  logic [127:0] io_data;
  logic [3:0]   io_valid;
  logic [3:0]   io_fifo_pop;
  logic         wb_valid;
  logic [4:0]   wb_rd;
  logic [31:0]  wb_data;
  logic         wb_ack;
  logic         busy;
  logic         done;
  logic [31:0]  perf_stall_cycles;

  int n_checks = 0;
  int n_errors = 0;

  // FIFO model
  logic [31:0] fmem [4][16];
  int          fhead [4];
  int          ftail [4];
  logic        flush_req;

  // Observation logs
  logic [4:0]  rd_log   [64];
  logic [31:0] data_log [64];
  int          wb_n = 0;
  int          done_n = 0;
  int          multi_pop_n = 0;

  int base_wb, base_done;
  int base_head [4];

  rca_writeback_arbiter dut (
    .clk                    (clk),
    .rst                    (rst),
    .start                  (start),
    .abort                  (abort),
    .out_mask               (out_mask),
    .rd_addrs               (rd_addrs),
    .expected_count         (exp_cnt),
    .io_unit_data_out       (io_data),
    .io_unit_data_valid_out (io_valid),
    .io_fifo_pop            (io_fifo_pop),
    .wb_valid               (wb_valid),
    .wb_rd                  (wb_rd),
    .wb_data                (wb_data),
    .wb_ack                 (wb_ack),
    .busy                   (busy),
    .done                   (done),
    .perf_stall_cycles      (perf_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int u = 0; u < 4; u++) begin
      if (flush_req) fhead[u] <= ftail[u];
      else if (io_fifo_pop[u]) fhead[u] <= fhead[u] + 1;
    end
  end

  always_comb begin
    io_valid = '0;
    io_data  = '0;
    for (int u = 0; u < 4; u++) begin
      io_valid[u]         = (fhead[u] != ftail[u]);
      io_data[u*32 +: 32] = fmem[u][fhead[u] % 16];
    end
  end

  always @(posedge clk) begin
    if (wb_valid && wb_ack) begin
      rd_log[wb_n % 64]   <= wb_rd;
      data_log[wb_n % 64] <= wb_data;
      wb_n <= wb_n + 1;
    end
    if (done) done_n <= done_n + 1;
    if ($countones(io_fifo_pop) > 1) multi_pop_n <= multi_pop_n + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int u, input logic [31:0] v);
    fmem[u][ftail[u] % 16] = v;
    ftail[u] = ftail[u] + 1;
  endtask

  task automatic flush();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
  endtask

  task automatic snap();
    base_wb   = wb_n;
    base_done = done_n;
    for (int u = 0; u < 4; u++) base_head[u] = fhead[u];
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 60) begin
      tick();
      k++;
    end
    check(tag, 64'(done), 64'd1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; out_mask = '0;
    rd_addrs = '0; exp_cnt = '0; wb_ack = 1'b0; flush_req = 1'b0;
    for (int u = 0; u < 4; u++) begin
      fhead[u] = 0;
      ftail[u] = 0;
    end

    // Reset state
    #2;
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_wb_rd", 64'(wb_rd), 64'd0);
    check("rst_wb_data", 64'(wb_data), 64'd0);
    check("rst_pop", 64'(io_fifo_pop), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_perf", 64'(perf_stall_cycles), 64'd0);
    #10 rst = 1'b1;
    tick();

    // Single unit: three results A,B,C to rd 7
    out_mask = 4'b0001; rd_addrs[4:0] = 5'd7; exp_cnt[15:0] = 16'd3; wb_ack = 1'b1;
    load(0, 32'hA); load(0, 32'hB); load(0, 32'hC);
    snap();
    start = 1'b1; tick(); start = 1'b0;
    check("su_busy", 64'(busy), 64'd1);
    check("su_valid0", 64'(wb_valid), 64'd0);
    check("su_pop0", 64'(io_fifo_pop), 64'h1);
    tick();
    check("su_data_a", 64'(wb_data), 64'hA);
    check("su_rd_a", 64'(wb_rd), 64'd7);
    check("su_pop1", 64'(io_fifo_pop), 64'h1);
    tick();
    check("su_data_b", 64'(wb_data), 64'hB);
    tick();
    check("su_data_c", 64'(wb_data), 64'hC);
    check("su_pop_none", 64'(io_fifo_pop), 64'h0);
    check("su_busy_c", 64'(busy), 64'd1);
    tick();
    check("su_done", 64'(done), 64'd1);
    check("su_busy_done", 64'(busy), 64'd0);
    check("su_valid_done", 64'(wb_valid), 64'd0);
    tick();
    check("su_done_clr", 64'(done), 64'd0);
    check("su_nwb", 64'(wb_n - base_wb), 64'd3);
    check("su_log_a", 64'(data_log[base_wb]), 64'hA);
    check("su_log_b", 64'(data_log[base_wb+1]), 64'hB);
    check("su_log_c", 64'(data_log[base_wb+2]), 64'hC);
    check("su_pops", 64'(fhead[0] - base_head[0]), 64'd3);

    // Round robin: 4 units x 2 results, grant order 0,1,2,3,0,1,2,3
    flush();
    out_mask = 4'b1111;
    for (int u = 0; u < 4; u++) begin
      rd_addrs[u*5 +: 5]  = 5'(10 + u);
      exp_cnt[u*16 +: 16] = 16'd2;
      for (int k = 0; k < 3; k++) load(u, 32'(256*u + k));
    end
    snap();
    start = 1'b1; tick(); start = 1'b0;
    wait_done("rr_done");
    check("rr_nwb", 64'(wb_n - base_wb), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rr_rd_%0d", i), 64'(rd_log[base_wb+i]), 64'(10 + (i % 4)));
      check($sformatf("rr_data_%0d", i), 64'(data_log[base_wb+i]), 64'(256*(i % 4) + (i / 4)));
    end
    for (int u = 0; u < 4; u++) begin
      check($sformatf("rr_pops_u%0d", u), 64'(fhead[u] - base_head[u]), 64'd2);
    end
    check("rr_one_pop", 64'(multi_pop_n), 64'd0);
    tick();

    // Backpressure: ack low for 5 cycles after first valid
    flush();
    out_mask = 4'b0001; rd_addrs[4:0] = 5'd7; exp_cnt[15:0] = 16'd3; wb_ack = 1'b0;
    load(0, 32'hA); load(0, 32'hB); load(0, 32'hC);
    snap();
    start = 1'b1; tick(); start = 1'b0;
    check("bp_pop0", 64'(io_fifo_pop), 64'h1);
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold_data_%0d", i), 64'(wb_data), 64'hA);
      check($sformatf("bp_hold_pop_%0d", i), 64'(io_fifo_pop), 64'h0);
      check($sformatf("bp_hold_valid_%0d", i), 64'(wb_valid), 64'd1);
      tick();
    end
    wb_ack = 1'b1;
    #1;
    check("bp_pop_on_ack", 64'(io_fifo_pop), 64'h1);
    wait_done("bp_done");
    check("bp_nwb", 64'(wb_n - base_wb), 64'd3);
    check("bp_log_a", 64'(data_log[base_wb]), 64'hA);
    check("bp_log_c", 64'(data_log[base_wb+2]), 64'hC);
`ifdef RCA_WB_PERF_EN
    check("bp_perf", 64'(perf_stall_cycles), 64'd5);
    tick();
    check("bp_perf_hold", 64'(perf_stall_cycles), 64'd5);
`else
    check("bp_perf_off", 64'(perf_stall_cycles), 64'd0);
    tick();
`endif

    // Zero work: mask 0, masked unit holds data but is never popped
    flush();
    out_mask = 4'b0000;
    load(1, 32'h55);
    snap();
    start = 1'b1; tick(); start = 1'b0;
    check("zw_busy", 64'(busy), 64'd1);
    check("zw_done0", 64'(done), 64'd0);
    check("zw_pop", 64'(io_fifo_pop), 64'h0);
    tick();
    check("zw_done", 64'(done), 64'd1);
    check("zw_valid", 64'(wb_valid), 64'd0);
    tick();
    check("zw_done_clr", 64'(done), 64'd0);
    check("zw_no_pops", 64'(fhead[1] - base_head[1]), 64'd0);
    check("zw_nwb", 64'(wb_n - base_wb), 64'd0);

    // Abort after 1 of 4 results with wb_valid high
    flush();
    out_mask = 4'b0001; rd_addrs[4:0] = 5'd3; exp_cnt[15:0] = 16'd4; wb_ack = 1'b1;
    load(0, 32'h11); load(0, 32'h12); load(0, 32'h13); load(0, 32'h14);
    snap();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("ab_valid", 64'(wb_valid), 64'd1);
    wb_ack = 1'b0; abort = 1'b1;
    #1;
    check("ab_no_pop", 64'(io_fifo_pop), 64'h0);
    tick();
    abort = 1'b0;
    check("ab_valid_clr", 64'(wb_valid), 64'd0);
    check("ab_busy", 64'(busy), 64'd0);
    check("ab_done", 64'(done), 64'd0);
    tick(); tick();
    check("ab_no_done", 64'(done_n - base_done), 64'd0);
    check("ab_pops", 64'(fhead[0] - base_head[0]), 64'd1);
    flush();
    exp_cnt[15:0] = 16'd2; wb_ack = 1'b1;
    load(0, 32'h21); load(0, 32'h22);
    snap();
    start = 1'b1; tick(); start = 1'b0;
    wait_done("ab_rerun_done");
    check("ab_rerun_nwb", 64'(wb_n - base_wb), 64'd2);
    check("ab_rerun_d0", 64'(data_log[base_wb]), 64'h21);
    check("ab_rerun_d1", 64'(data_log[base_wb+1]), 64'h22);
    check("ab_rerun_rd", 64'(rd_log[base_wb+1]), 64'd3);
    tick();

    // Asynchronous reset mid-run
    flush();
    exp_cnt[15:0] = 16'd4;
    load(0, 32'h31); load(0, 32'h32); load(0, 32'h33); load(0, 32'h34);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("ar_pre_valid", 64'(wb_valid), 64'd1);
    #3 rst = 1'b0;
    #1;
    check("ar_valid", 64'(wb_valid), 64'd0);
    check("ar_pop", 64'(io_fifo_pop), 64'h0);
    check("ar_busy", 64'(busy), 64'd0);
    check("ar_done", 64'(done), 64'd0);
    #2 rst = 1'b1;
    tick();
    check("ar_idle_busy", 64'(busy), 64'd0);
    check("ar_idle_valid", 64'(wb_valid), 64'd0);
    check("ar_idle_data", 64'(wb_data), 64'd0);
    check("ar_idle_pop", 64'(io_fifo_pop), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rca_writeback_arbiter.md
Name: rca_writeback_arbiter

Overview:
- Downstream consumer of the PR grid's IO units when they run in output mode.
- Drains each enabled IO unit's output FIFO under round-robin arbitration, pops the FIFO on capture and presents one result per cycle to the register-file writeback port through a registered valid/ack stage.
- Counts the results expected per unit and signals completion of the accelerated region to the RCA control unit.

Parameters:
- NUM_IO_UNITS, 4, number of IO units / arbitration requesters
- XLEN, 32, data width
- COUNT_W, 16, width of per-unit expected-result counters
- RD_W, 5, destination register index width

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; latch configuration and begin collecting
- abort  input  1  one-cycle pulse; cancel the current run
- out_mask  input  NUM_IO_UNITS  units acting as result producers
- rd_addrs  input  RD_W x NUM_IO_UNITS  destination register per unit
- expected_count  input  COUNT_W x NUM_IO_UNITS  results expected per unit
- io_unit_data_out  input  XLEN x NUM_IO_UNITS  FIFO head data from IO units
- io_unit_data_valid_out  input  1 x NUM_IO_UNITS  FIFO head valid
- io_fifo_pop  output  1 x NUM_IO_UNITS  pop pulse to the IO unit FIFO
- wb_valid  output  1  writeback request
- wb_rd  output  RD_W  writeback register index
- wb_data  output  XLEN  writeback data
- wb_ack  input  1  writeback accepted this cycle
- busy  output  1  run in progress
- done  output  1  one-cycle completion pulse
- perf_stall_cycles  output  32  stall counter (see Optional Feature)

Behaviour:
- Reset (rst low, async): state IDLE; wb_valid=0, wb_rd=0, wb_data=0, io_fifo_pop all 0, busy=0, done=0, all counters 0, round-robin pointer 0.
- Module-wide, io_fifo_pop is 0 unless the state is RUN.
- State IDLE:
  - start -> RUN.
  - Latch out_mask, rd_addrs and expected_count. A unit's remaining count is loaded as 0 if its mask bit is clear.
  - Round-robin pointer reset to 0.
- State RUN, busy=1:
  - A unit is eligible when its mask bit is set, its valid is 1 and its remaining count is nonzero.
  - Capture is allowed when !wb_valid || wb_ack.
  - On capture, pick the first eligible unit searching from the pointer upward with wrap. Register its data into wb_data and its rd into wb_rd, set wb_valid=1 next cycle, pulse io_fifo_pop[unit] the same cycle, decrement that unit's remaining count, and set pointer = unit+1 mod NUM_IO_UNITS.
  - At most one pop per cycle.
  - wb_ack with no capture -> wb_valid=0 next cycle.
  - wb_data and wb_rd hold stable while wb_valid && !wb_ack.
  - Back-to-back: ack and capture in the same cycle gives one result per cycle sustained.
  - Exit to DONE when all remaining counts are 0 and (wb_valid=0 or wb_ack this cycle).
- State DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
- start while RUN or DONE is ignored.
- abort in RUN (abort has priority over capture):
  - No pop that cycle.
  - -> IDLE next cycle with wb_valid=0 and counts cleared.
  - done is not asserted.
- Boundary cases:
  - All remaining counts 0 at start (mask 0 or counts 0): RUN for one cycle, then DONE.
  - Data arriving from masked units or exhausted units is never popped.
  - Valid dropping on an unpicked unit has no effect.
  - Counter arithmetic is unsigned, never decrements below 0; expected_count max = 2^COUNT_W-1.

Optional Feature:
- Macro RCA_WB_PERF_EN.
- Defined: a 32-bit saturating counter increments each cycle with wb_valid && !wb_ack in RUN. It is cleared on start, and its value is held after DONE until the next start.
- Undefined: counter logic omitted; perf_stall_cycles tied to 0.

Decomposition:
- Shared package rca_config: WB_COUNT_W, wb_state_t enum (IDLE, RUN, DONE), and typedefs for the rd and count arrays indexed by NUM_IO_UNITS.
- One sub-module rca_rr_picker:
  - Parameter N.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, grant index, any_grant.
  - Purely combinational.

Test Plan:
- Single unit:
  - Stimulus: mask=0001, count[0]=3, rd[0]=7; unit 0 valid with data 0xA, 0xB, 0xC; wb_ack held 1.
  - Response: three consecutive writebacks to rd 7 with 0xA, 0xB, 0xC; three pops; done pulses on the cycle after the last ack; busy low afterwards.
- Round robin:
  - Stimulus: mask=1111, count=2 each; all units valid continuously; ack=1.
  - Response: grant order 0,1,2,3,0,1,2,3; 8 writebacks; no pops after counts are exhausted.
- Backpressure:
  - Stimulus: as the single-unit case, but wb_ack=0 for 5 cycles after the first valid.
  - Response: wb_data stays 0xA; no second pop until ack; with RCA_WB_PERF_EN, perf_stall_cycles=5.
- Zero work:
  - Stimulus: start with mask=0000.
  - Response: done at start+2; no pops; wb_valid never asserted.
- Abort:
  - Stimulus: abort in RUN after 1 of 4 results, with wb_valid=1.
  - Response: no pop in the abort cycle; next cycle IDLE with wb_valid=0; done never pulses; a following start runs normally.
- Async reset:
  - Stimulus: rst low mid-RUN, not aligned to clk.
  - Response: wb_valid, pops, busy and done all 0 immediately; IDLE after release.
